mips_decode_stage: RTL and testbench
====================================

MIPS_DECODE_STAGE -- requirements
Module: mips_decode_stage

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit datapath, 5-bit register index.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 if_valid  in  1  fetch presents valid instruction this cycle.
REQ-005 if_pc  in  32  address of fetched instruction.
REQ-006 if_inst  in  32  fetched instruction word.
REQ-007 flush  in  1  branch taken in EX; kill younger instructions.
REQ-008 wb_we, wb_addr, wb_data  in  1/5/32  register-file write port from WB.
REQ-009 stall_out  out  1  load-use hazard; fetch SHALL hold PC and if_inst.
REQ-010 jump_taken, jump_target  out  1/32  combinational J redirect to fetch.
REQ-011 ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  1/32/32/32/32  registered ID/EX payload.
REQ-012 ex_rs, ex_rt, ex_dst  out  5 each  registered source and destination indices.
REQ-013 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each  registered controls.
REQ-014 ex_alu_op  out  4  ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5.
REQ-015 illegal  out  1  registered; unsupported opcode/funct reached ID/EX.

Function
REQ-016 IF/ID register SHALL hold {valid, pc, inst}; loads if_valid/if_pc/if_inst each edge unless held or killed.
REQ-017 Register file SHALL be 32x32; r0 reads 0; write on edge when wb_we && wb_addr!=0.
REQ-018 Reads SHALL bypass same-cycle write: wb_we && wb_addr==src && src!=0 -> wb_data.
REQ-019 Decode: R-type op 0x00 funct 0x20/0x22/0x24/0x25/0x2A/0x00 -> ADD/SUB/AND/OR/SLT/SLL, dst=rd, reg_write=1.
REQ-020 lw 0x23: ADD, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, dst=rt.
REQ-021 sw 0x2B: ADD, alu_src=1, mem_write=1; beq 0x04: SUB, branch=1; addi 0x08: ADD, alu_src=1, reg_write=1, dst=rt.
REQ-022 j 0x02: all ex controls 0; jump_taken=1 when IF/ID valid and stall_out=0 and flush=0.
REQ-023 jump_target = {pc4[31:28], inst[25:0], 2'b00}; pc4 = IF/ID pc + 4, wrap mod 2^32.
REQ-024 ex_imm SHALL be sign-extended inst[15:0]; ex_pc4 = IF/ID pc + 4.
REQ-025 Other opcode/funct: all controls 0, illegal=1, ex_valid=1.
REQ-026 stall_out = ex_valid && ex_mem_read && ex_dst!=0 && (ex_dst==rs || (ex_dst==rt && instruction reads rt)) && IF/ID valid.
REQ-027 rt is read by R-type, sw, beq only.
REQ-028 stall_out=1: IF/ID holds; ID/EX loads bubble (ex_valid=0, all controls 0); exactly one bubble per load-use.
REQ-029 jump_taken=1: ID/EX loads j as bubble; IF/ID loads invalid next edge (kills delay-slot fetch).
REQ-030 flush=1: IF/ID and ID/EX both load bubbles; flush overrides stall_out and jump_taken.
REQ-031 IF/ID invalid: ID/EX loads bubble; stall_out=0, jump_taken=0.
REQ-032 Bubble SHALL zero controls; payload fields may hold any value.

Reset
REQ-033 rst=1 SHALL immediately clear IF/ID valid, ex_valid, all ex controls, illegal, ex indices, all 32 registers.
REQ-034 During reset stall_out=0, jump_taken=0; first edge after release samples if_* normally.
REQ-035 Reset mid-stall or mid-jump SHALL discard pending instruction; no writeback of held state.

Verification
REQ-036 Write r5=0x1234 via WB, then add r3,r5,r0 -> ex_rs_data=0x1234, ex_alu_op=0, ex_dst=3, ex_reg_write=1.
REQ-037 WB writes r7=0xDEAD in same cycle add r1,r7,r7 is in ID -> ex_rs_data=ex_rt_data=0xDEAD.
REQ-038 lw r2,8(r1) then add r4,r2,r3 -> stall_out=1 one cycle, one bubble, add reissued with stall_out=0.
REQ-039 j 0x0000100 at pc 0x00400010 -> jump_taken=1, jump_target=0x00000400, next IF/ID invalid.
REQ-040 flush with stall_out=1 active -> both stages bubble, stall_out=0 next cycle; addi r0,r0,-1 -> ex_imm=0xFFFFFFFF, r0 still reads 0.
REQ-041 Opcode 0x3F -> illegal=1, controls 0; assert rst mid-stream -> all outputs 0 before next clk edge.

Source files
------------

// File: rtl/mips_decode_stage_if.sv
// Decode-stage bus: fetch and writeback inputs, hazard/redirect outputs and the registered
// ID/EX payload handed to execute.
interface mips_decode_stage_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_out;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        ex_valid;
    logic [31:0] ex_pc4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dst;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_alu_src;
    logic        ex_branch;
    logic [3:0]  ex_alu_op;
    logic        illegal;

    modport master (
        output if_valid, if_pc, if_inst, flush, wb_we, wb_addr, wb_data,
        input  stall_out, jump_taken, jump_target, ex_valid, ex_pc4, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op, illegal
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush, wb_we, wb_addr, wb_data,
        output stall_out, jump_taken, jump_target, ex_valid, ex_pc4, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op, illegal
    );
endinterface

// File: rtl/mips_decode_stage.sv
// MIPS ID stage: IF/ID register, 32x32 register file with WB bypass, decoder,
// load-use stall, J redirect and the ID/EX pipeline register.
module mips_decode_stage (
    input logic                clk,
    input logic                rst,
    mips_decode_stage_if.slave bus
);
    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluSlt = 4'd4,
        AluSll = 4'd5
    } alu_op_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_inst_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    assign op    = id_inst_q[31:26];
    assign funct = id_inst_q[5:0];
    assign rs    = id_inst_q[25:21];
    assign rt    = id_inst_q[20:16];
    assign rd    = id_inst_q[15:11];
    assign pc4   = id_pc_q + 32'd4;

    // A write landing this edge is visible to the instruction reading it now.
    assign rs_data = (rs == 5'd0) ? 32'd0 :
                     (bus.wb_we && bus.wb_addr == rs) ? bus.wb_data : rf_q[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 :
                     (bus.wb_we && bus.wb_addr == rt) ? bus.wb_data : rf_q[rt];

    logic    dec_reg_write;
    logic    dec_mem_read;
    logic    dec_mem_write;
    logic    dec_mem_to_reg;
    logic    dec_alu_src;
    logic    dec_branch;
    logic    dec_illegal;
    logic    dec_jump;
    logic    dec_reads_rt;
    alu_op_e dec_alu_op;
    logic [4:0] dec_dst;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_illegal    = 1'b0;
        dec_jump       = 1'b0;
        dec_reads_rt   = 1'b0;
        dec_alu_op     = AluAdd;
        dec_dst        = 5'd0;
        case (op)
            OpRtype: begin
                dec_reads_rt  = 1'b1;
                dec_reg_write = 1'b1;
                dec_dst       = rd;
                case (funct)
                    6'h20:   dec_alu_op = AluAdd;
                    6'h22:   dec_alu_op = AluSub;
                    6'h24:   dec_alu_op = AluAnd;
                    6'h25:   dec_alu_op = AluOr;
                    6'h2A:   dec_alu_op = AluSlt;
                    6'h00:   dec_alu_op = AluSll;
                    default: begin
                        dec_reg_write = 1'b0;
                        dec_dst       = 5'd0;
                        dec_illegal   = 1'b1;
                    end
                endcase
            end
            OpLw: begin
                dec_alu_src    = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_dst        = rt;
            end
            OpSw: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_reads_rt  = 1'b1;
            end
            OpBeq: begin
                dec_alu_op   = AluSub;
                dec_branch   = 1'b1;
                dec_reads_rt = 1'b1;
            end
            OpAddi: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_dst       = rt;
            end
            OpJ:     dec_jump    = 1'b1;
            default: dec_illegal = 1'b1;
        endcase
    end

    logic stall;
    logic jump;
    logic issue;

    assign stall = id_valid_q && bus.ex_valid && bus.ex_mem_read && bus.ex_dst != 5'd0 &&
                   (bus.ex_dst == rs || (bus.ex_dst == rt && dec_reads_rt));
    assign jump  = id_valid_q && dec_jump && !stall && !bus.flush;
    // J resolves here, so it never occupies ID/EX as a real instruction.
    assign issue = id_valid_q && !bus.flush && !stall && !dec_jump;

    assign bus.stall_out   = stall;
    assign bus.jump_taken  = jump;
    assign bus.jump_target = {pc4[31:28], id_inst_q[25:0], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (bus.wb_we && bus.wb_addr != 5'd0) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_inst_q  <= 32'd0;
        end else if (bus.flush || jump) begin
            id_valid_q <= 1'b0;
        end else if (!stall) begin
            id_valid_q <= bus.if_valid;
            id_pc_q    <= bus.if_pc;
            id_inst_q  <= bus.if_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_pc4        <= 32'd0;
            bus.ex_rs_data    <= 32'd0;
            bus.ex_rt_data    <= 32'd0;
            bus.ex_imm        <= 32'd0;
            bus.ex_rs         <= 5'd0;
            bus.ex_rt         <= 5'd0;
            bus.ex_dst        <= 5'd0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.ex_alu_op     <= AluAdd;
            bus.illegal       <= 1'b0;
        end else begin
            bus.ex_valid      <= issue;
            bus.ex_pc4        <= pc4;
            bus.ex_rs_data    <= rs_data;
            bus.ex_rt_data    <= rt_data;
            bus.ex_imm        <= {{16{id_inst_q[15]}}, id_inst_q[15:0]};
            bus.ex_rs         <= rs;
            bus.ex_rt         <= rt;
            bus.ex_dst        <= dec_dst;
            bus.ex_reg_write  <= issue && dec_reg_write;
            bus.ex_mem_read   <= issue && dec_mem_read;
            bus.ex_mem_write  <= issue && dec_mem_write;
            bus.ex_mem_to_reg <= issue && dec_mem_to_reg;
            bus.ex_alu_src    <= issue && dec_alu_src;
            bus.ex_branch     <= issue && dec_branch;
            bus.ex_alu_op     <= issue ? dec_alu_op : AluAdd;
            bus.illegal       <= issue && dec_illegal;
        end
    end
endmodule

// File: tb/tb_mips_decode_stage.sv
// Scoreboard bench for mips_decode_stage: transaction-level pipeline model feeds an
// expected-issue queue that an independent monitor drains whenever ex_valid is seen.
module tb_mips_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_decode_stage_if bus ();

    mips_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, illegal;
        logic       is_j, reads_rt;
        logic [4:0] dst;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dst;
        logic [3:0]  alu_op;
        logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, illegal;
    } item_t;

    item_t exp_q[$];

    // Model state: architectural registers plus what sits in ID and the hazard-relevant
    // part of what sits in EX.
    logic [31:0] m_regs [32];
    logic        m_id_valid = 1'b0;
    logic [31:0] m_id_pc = '0;
    logic [31:0] m_id_inst = '0;
    logic        m_ex_valid = 1'b0;
    logic        m_ex_mem_read = 1'b0;
    logic [4:0]  m_ex_dst = '0;

    logic [5:0] functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] inst);
        dec_t d;
        d = '0;
        case (inst[31:26])
            6'h00: begin
                d.reads_rt = 1'b1;
                case (inst[5:0])
                    6'h20:   d.alu_op = 4'd0;
                    6'h22:   d.alu_op = 4'd1;
                    6'h24:   d.alu_op = 4'd2;
                    6'h25:   d.alu_op = 4'd3;
                    6'h2A:   d.alu_op = 4'd4;
                    6'h00:   d.alu_op = 4'd5;
                    default: d.illegal = 1'b1;
                endcase
                if (!d.illegal) begin
                    d.reg_write = 1'b1;
                    d.dst = inst[15:11];
                end
            end
            6'h23: begin
                d.alu_src = 1'b1; d.mem_read = 1'b1; d.mem_to_reg = 1'b1;
                d.reg_write = 1'b1; d.dst = inst[20:16];
            end
            6'h2B: begin d.alu_src = 1'b1; d.mem_write = 1'b1; d.reads_rt = 1'b1; end
            6'h04: begin d.alu_op = 4'd1; d.branch = 1'b1; d.reads_rt = 1'b1; end
            6'h08: begin d.alu_src = 1'b1; d.reg_write = 1'b1; d.dst = inst[20:16]; end
            6'h02: d.is_j = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic ref_stall();
        dec_t d;
        logic [4:0] src_s, src_t;
        d = ref_decode(m_id_inst);
        src_s = m_id_inst[25:21];
        src_t = m_id_inst[20:16];
        return m_id_valid && m_ex_valid && m_ex_mem_read && m_ex_dst != 5'd0 &&
               (m_ex_dst == src_s || (d.reads_rt && m_ex_dst == src_t));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_id_valid = 1'b0;
        m_ex_valid = 1'b0;
        m_ex_mem_read = 1'b0;
        exp_q.delete();
    endtask

    // One clock edge of the reference pipeline, using the inputs currently on the bus.
    task automatic model_step();
        dec_t  d;
        item_t it;
        logic  st, jt, go;
        logic [4:0] src_s, src_t;
        d = ref_decode(m_id_inst);
        st = ref_stall();
        src_s = m_id_inst[25:21];
        src_t = m_id_inst[20:16];
        jt = m_id_valid && d.is_j && !st && !bus.flush;
        if (bus.wb_we && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
        go = m_id_valid && !bus.flush && !st && !d.is_j;
        if (go) begin
            it.pc4 = m_id_pc + 32'd4;
            it.rs_data = m_regs[src_s];
            it.rt_data = m_regs[src_t];
            it.imm = 32'($signed(m_id_inst[15:0]));
            it.rs = src_s;
            it.rt = src_t;
            it.dst = d.reg_write ? d.dst : 5'd0;
            it.alu_op = d.alu_op;
            it.reg_write = d.reg_write;
            it.mem_read = d.mem_read;
            it.mem_write = d.mem_write;
            it.mem_to_reg = d.mem_to_reg;
            it.alu_src = d.alu_src;
            it.branch = d.branch;
            it.illegal = d.illegal;
            exp_q.push_back(it);
        end
        m_ex_valid = go;
        m_ex_mem_read = go && d.mem_read;
        m_ex_dst = d.dst;
        if (bus.flush || jt) begin
            m_id_valid = 1'b0;
        end else if (!st) begin
            m_id_valid = bus.if_valid;
            m_id_pc = bus.if_pc;
            m_id_inst = bus.if_inst;
        end
    endtask

    // Starts and ends at a falling edge; checks the combinational outputs before the edge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        dec_t d;
        logic st, jt;
        bus.if_valid = v;
        bus.if_pc = pc;
        bus.if_inst = inst;
        bus.flush = fl;
        bus.wb_we = we;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        #1;
        d = ref_decode(m_id_inst);
        st = ref_stall();
        jt = m_id_valid && d.is_j && !st && !fl;
        check("stall_out", 32'(bus.stall_out), 32'(st));
        check("jump_taken", 32'(bus.jump_taken), 32'(jt));
        if (jt) check("jump_target", bus.jump_target,
                      ((m_id_pc + 32'd4) & 32'hF000_0000) | (32'(m_id_inst[25:0]) << 2));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        drive(1'b1, pc, inst, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  a = 5'($urandom_range(7));
        logic [4:0]  b = 5'($urandom_range(7));
        logic [4:0]  c = 5'($urandom_range(7));
        logic [15:0] imm = 16'($urandom());
        case ($urandom_range(11))
            0, 1:    return {6'h00, a, b, c, 5'($urandom_range(31)), functs[$urandom_range(5)]};
            2, 3, 4: return itype(6'h23, a, b, imm);
            5:       return itype(6'h2B, a, b, imm);
            6:       return itype(6'h04, a, b, imm);
            7:       return itype(6'h08, a, b, imm);
            8:       return {6'h02, 26'($urandom())};
            9:       return {6'h00, a, b, c, 5'd0, 6'($urandom())};
            10:      return {6'h3F, 26'($urandom())};
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [31:0] ctrl_bits();
        return 32'({bus.ex_alu_op, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                    bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_branch});
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_valid"}, 32'(bus.ex_valid), 32'd0);
        check({tag, "_ctrl"}, ctrl_bits(), 32'd0);
        check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        check({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
        check({tag, "_jump"}, 32'(bus.jump_taken), 32'd0);
        check({tag, "_idx"}, 32'({bus.ex_rs, bus.ex_rt, bus.ex_dst}), 32'd0);
    endtask

    // Monitor: pops one expected issue per ex_valid; bubbles must carry zero controls.
    always @(posedge clk) begin
        item_t e, a;
        #1;
        if (bus.ex_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ex_issue: got unexpected issue with ex_pc4 %0h, expected none",
                         bus.ex_pc4);
            end else begin
                e = exp_q.pop_front();
                a = {bus.ex_pc4, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm, bus.ex_rs,
                     bus.ex_rt, e.reg_write ? bus.ex_dst : 5'd0, bus.ex_alu_op,
                     bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
                     bus.ex_alu_src, bus.ex_branch, bus.illegal};
                if (a !== e) begin
                    n_err++;
                    $display("FAIL ex_item: got %h, expected %h", a, e);
                end
            end
        end else begin
            n_vec++;
            if ({ctrl_bits(), bus.illegal} !== 33'd0) begin
                n_err++;
                $display("FAIL bubble_ctrl: got %0h, expected 0", {ctrl_bits(), bus.illegal});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc, inst;
        logic v;
        model_reset();
        bus.if_valid = 1'b0;
        bus.if_pc = '0;
        bus.if_inst = '0;
        bus.flush = 1'b0;
        bus.wb_we = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // WB write then a consumer
        drive(1'b0, '0, '0, 1'b0, 1'b1, 5'd5, 32'h1234);
        fetch(32'h100, rtype(5'd3, 5'd5, 5'd0, 6'h20));
        idle();
        check("add_rs_data", bus.ex_rs_data, 32'h1234);
        check("add_alu_op", 32'(bus.ex_alu_op), 32'd0);
        check("add_dst", 32'(bus.ex_dst), 32'd3);
        check("add_reg_write", 32'(bus.ex_reg_write), 32'd1);

        // Same-cycle WB bypass
        fetch(32'h104, rtype(5'd1, 5'd7, 5'd7, 6'h20));
        drive(1'b0, '0, '0, 1'b0, 1'b1, 5'd7, 32'hDEAD);
        check("bypass_rs", bus.ex_rs_data, 32'hDEAD);
        check("bypass_rt", bus.ex_rt_data, 32'hDEAD);

        // Load-use: one stall, one bubble, consumer reissued
        fetch(32'h108, itype(6'h23, 5'd1, 5'd2, 16'd8));
        fetch(32'h10C, rtype(5'd4, 5'd2, 5'd3, 6'h20));
        check("lu_stall", 32'(bus.stall_out), 32'd1);
        idle();
        check("lu_bubble", 32'(bus.ex_valid), 32'd0);
        check("lu_stall_clear", 32'(bus.stall_out), 32'd0);
        idle();
        check("lu_reissue_valid", 32'(bus.ex_valid), 32'd1);
        check("lu_reissue_dst", 32'(bus.ex_dst), 32'd4);

        // J redirect kills the delay-slot fetch
        fetch(32'h0040_0010, {6'h02, 26'h000_0100});
        check("j_taken", 32'(bus.jump_taken), 32'd1);
        check("j_target", bus.jump_target, 32'h0000_0400);
        fetch(32'h0040_0014, rtype(5'd5, 5'd1, 5'd1, 6'h20));
        check("j_bubble", 32'(bus.ex_valid), 32'd0);
        idle();
        check("j_slot_killed", 32'(bus.ex_valid), 32'd0);

        // Flush overrides an active stall; addi to r0 and r0 write attempt
        fetch(32'h200, itype(6'h23, 5'd1, 5'd2, 16'd0));
        fetch(32'h204, rtype(5'd4, 5'd2, 5'd3, 6'h20));
        check("fl_stall", 32'(bus.stall_out), 32'd1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        check("fl_bubble", 32'(bus.ex_valid), 32'd0);
        check("fl_stall_clear", 32'(bus.stall_out), 32'd0);
        fetch(32'h208, itype(6'h08, 5'd0, 5'd0, 16'hFFFF));
        drive(1'b1, 32'h20C, rtype(5'd6, 5'd0, 5'd0, 6'h20), 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check("addi_imm", bus.ex_imm, 32'hFFFF_FFFF);
        check("addi_r0", bus.ex_rs_data, 32'd0);
        idle();
        check("r0_after_write", bus.ex_rs_data, 32'd0);

        // Illegal opcode
        fetch(32'h300, {6'h3F, 26'd0});
        idle();
        check("ill_flag", 32'(bus.illegal), 32'd1);
        check("ill_valid", 32'(bus.ex_valid), 32'd1);
        check("ill_ctrl", ctrl_bits(), 32'd0);

        // Asynchronous reset in the middle of a stall
        fetch(32'h304, itype(6'h23, 5'd1, 5'd2, 16'd0));
        fetch(32'h308, rtype(5'd4, 5'd2, 5'd3, 6'h20));
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle();
        check("rst_discard", 32'(bus.ex_valid), 32'd0);
        fetch(32'h400, rtype(5'd3, 5'd5, 5'd7, 6'h20));
        idle();
        check("rst_regs_valid", 32'(bus.ex_valid), 32'd1);
        check("rst_regs_cleared", bus.ex_rs_data | bus.ex_rt_data, 32'd0);

        // Randomized stream; fetch holds its instruction while stalled
        pc = 32'h0040_0000;
        inst = '0;
        v = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!ref_stall()) begin
                v = ($urandom_range(9) < 8);
                inst = rand_inst();
                pc = pc + 32'd4;
            end
            drive(v, pc, inst, ($urandom_range(15) == 0), 1'($urandom_range(1)),
                  5'($urandom_range(7)), $urandom());
        end
        idle();
        idle();
        idle();
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
